// File: rtl/aer_tx_arbiter.sv
// Round-robin arbiter sharing one outgoing AER bus between N_REQ local sources.
// Encodes the granted index on aer_addr, runs the 4-phase req/ack with the receiver, then frees the source.
module aer_tx_arbiter #(
    parameter int N_REQ       = 8,
    parameter int ADDR_W      = 3,
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  src_req,
    output logic [N_REQ-1:0]  src_ack,
    output logic [ADDR_W-1:0] aer_addr,
    output logic              aer_req,
    input  logic              aer_ack,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       event_cnt,
    output logic [1:0]        fsm_state
);

    localparam int SC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC + 1) : 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_nxt, last_grant, last_nxt, pick;
    logic [SC_W-1:0]    setup_cnt, setup_nxt;
    logic [TO_W-1:0]    wait_cnt, wait_nxt;
    logic [N_REQ-1:0]   ack_nxt, grant_onehot;
    logic               req_nxt, terr_nxt, busy_nxt;
    logic [15:0]        cnt_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic               ack_s;

    assign ack_s        = ack_sync[SYNC_STAGES-1];
    assign grant_onehot = N_REQ'(1) << aer_addr;
    assign fsm_state    = state;

    // Rotating priority: the search starts one past the previous grant and wraps.
    always_comb begin
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(last_grant) + 1 + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && src_req[idx[ADDR_W-1:0]]) begin
                pick  = idx[ADDR_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Bus handshake is 4-phase: aer_addr settles, aer_req rises, receiver raises aer_ack,
    // aer_req falls, receiver drops aer_ack; the source sees the same pattern on src_req/src_ack.
    always_comb begin
        state_nxt = state;
        addr_nxt  = aer_addr;
        last_nxt  = last_grant;
        setup_nxt = setup_cnt;
        wait_nxt  = wait_cnt;
        ack_nxt   = src_ack;
        req_nxt   = aer_req;
        terr_nxt  = 1'b0;
        cnt_nxt   = event_cnt;
        case (state)
            IDLE: begin
                if (|src_req) begin
                    addr_nxt  = pick;
                    setup_nxt = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt == SC_W'(SETUP_CYC)) begin
                    req_nxt   = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = WAIT_ACK;
                end else begin
                    setup_nxt = setup_cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    ack_nxt   = grant_onehot;
                    cnt_nxt   = event_cnt + 16'd1;
                    state_nxt = WAIT_REL;
                end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    // Receiver never answered: drop the event but still free the source.
                    req_nxt   = 1'b0;
                    terr_nxt  = 1'b1;
                    ack_nxt   = grant_onehot;
                    state_nxt = WAIT_REL;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!ack_s && !src_req[aer_addr]) begin
                    ack_nxt   = '0;
                    last_nxt  = aer_addr;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            aer_addr    <= '0;
            last_grant  <= ADDR_W'(N_REQ - 1);
            setup_cnt   <= '0;
            wait_cnt    <= '0;
            src_ack     <= '0;
            aer_req     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            event_cnt   <= '0;
            ack_sync    <= '0;
        end else begin
            state       <= state_nxt;
            aer_addr    <= addr_nxt;
            last_grant  <= last_nxt;
            setup_cnt   <= setup_nxt;
            wait_cnt    <= wait_nxt;
            src_ack     <= ack_nxt;
            aer_req     <= req_nxt;
            timeout_err <= terr_nxt;
            busy        <= busy_nxt;
            event_cnt   <= cnt_nxt;
            ack_sync    <= {ack_sync[SYNC_STAGES-2:0], aer_ack};
        end
    end

endmodule

// File: tb/tb_aer_tx_arbiter.sv
// Directed bench for aer_tx_arbiter: latency, rotation, stuck source, timeout, async reset, counter wrap.
module tb_aer_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src_req;
    logic [7:0]  src_ack;
    logic [2:0]  aer_addr;
    logic        aer_req;
    logic        aer_ack;
    logic        busy;
    logic        timeout_err;
    logic [15:0] event_cnt;
    logic [1:0]  fsm_state;

    int          n_pass;
    int          n_total;
    logic [15:0] exp_cnt;

    aer_tx_arbiter #(
        .N_REQ(8), .ADDR_W(3), .SETUP_CYC(2), .SYNC_STAGES(2), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_ack(src_ack),
        .aer_addr(aer_addr), .aer_req(aer_req), .aer_ack(aer_ack), .busy(busy),
        .timeout_err(timeout_err), .event_cnt(event_cnt), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        for (int i = 0; i < 1000 && aer_req !== lvl; i++) tick(1);
        chk(tag, aer_req, lvl);
    endtask

    task automatic wait_src_ack(input logic [7:0] exp, input string tag);
        for (int i = 0; i < 1000 && src_ack !== exp; i++) tick(1);
        chk(tag, src_ack, exp);
    endtask

    // One complete successful event for source g, the only requester.
    task automatic serve(input int g, input string tag);
        src_req[g] = 1'b1;
        wait_req(1'b1, {tag, "_req"});
        chk({tag, "_addr"}, aer_addr, g);
        aer_ack = 1'b1;
        wait_src_ack(8'(1 << g), {tag, "_ack"});
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_cnt"}, event_cnt, exp_cnt);
        src_req = '0;
        aer_ack = 1'b0;
        wait_src_ack(8'h00, {tag, "_rel"});
    endtask

    // Round-robin step: others stay pending, the granted source drops then re-requests.
    task automatic rr_step(input int g, input bit rereq);
        wait_req(1'b1, "rr_req");
        chk("rr_addr", aer_addr, g);
        aer_ack = 1'b1;
        wait_src_ack(8'(1 << g), "rr_ack");
        exp_cnt = exp_cnt + 16'd1;
        src_req[g] = 1'b0;
        aer_ack = 1'b0;
        wait_src_ack(8'h00, "rr_rel");
        if (rereq) src_req[g] = 1'b1;
        else src_req = '0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = '0;
        src_req = '0;
        aer_ack = 1'b0;
        rst_n   = 1'b0;
        tick(3);
        chk("rst_src_ack", src_ack, 8'h00);
        chk("rst_addr", aer_addr, 3'd0);
        chk("rst_req", aer_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_cnt", event_cnt, 16'd0);
        chk("rst_state", fsm_state, 2'd0);
        rst_n = 1'b1;
        tick(1);

        // Single source with exact latencies.
        src_req = 8'h08;
        tick(1);
        chk("s1_addr", aer_addr, 3'd3);
        chk("s1_busy", busy, 1'b1);
        chk("s1_state", fsm_state, 2'd1);
        chk("s1_req_early", aer_req, 1'b0);
        tick(2);
        chk("s1_req_setup", aer_req, 1'b0);
        tick(1);
        chk("s1_req_rise", aer_req, 1'b1);
        tick(4);
        aer_ack = 1'b1;
        tick(2);
        chk("s1_sync_lat_ack", src_ack, 8'h00);
        chk("s1_sync_lat_req", aer_req, 1'b1);
        tick(1);
        chk("s1_src_ack", src_ack, 8'h08);
        chk("s1_req_fall", aer_req, 1'b0);
        chk("s1_addr_hold", aer_addr, 3'd3);
        exp_cnt = 16'd1;
        chk("s1_cnt", event_cnt, exp_cnt);
        aer_ack = 1'b0;
        src_req = 8'h00;
        tick(2);
        chk("s1_rel_wait", src_ack, 8'h08);
        tick(1);
        chk("s1_rel", src_ack, 8'h00);
        chk("s1_idle", busy, 1'b0);

        // Fresh start so rotation begins after source 7.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_cnt = '0;
        tick(1);
        src_req = 8'b1000_0101;
        rr_step(0, 1'b1);
        rr_step(2, 1'b1);
        rr_step(7, 1'b1);
        rr_step(0, 1'b1);
        rr_step(2, 1'b1);
        rr_step(7, 1'b0);
        chk("rr_cnt", event_cnt, exp_cnt);

        // Stuck source 4 blocks source 5.
        src_req = 8'h10;
        wait_req(1'b1, "stk_req");
        chk("stk_addr4", aer_addr, 3'd4);
        aer_ack = 1'b1;
        wait_src_ack(8'h10, "stk_ack4");
        exp_cnt = exp_cnt + 16'd1;
        aer_ack = 1'b0;
        src_req = 8'h30;
        tick(20);
        chk("stk_no_req", aer_req, 1'b0);
        chk("stk_hold_ack", src_ack, 8'h10);
        chk("stk_busy", busy, 1'b1);
        chk("stk_addr_hold", aer_addr, 3'd4);
        src_req = 8'h20;
        wait_src_ack(8'h00, "stk_rel4");
        wait_req(1'b1, "stk_req5");
        chk("stk_addr5", aer_addr, 3'd5);
        aer_ack = 1'b1;
        wait_src_ack(8'h20, "stk_ack5");
        exp_cnt = exp_cnt + 16'd1;
        chk("stk_cnt", event_cnt, exp_cnt);
        src_req = '0;
        aer_ack = 1'b0;
        wait_src_ack(8'h00, "stk_rel5");

        // Receiver never answers.
        src_req = 8'h02;
        wait_req(1'b1, "to_req");
        begin
            int n;
            n = 0;
            while (aer_req === 1'b1 && n < 400) begin
                tick(1);
                n++;
            end
            chk("to_cycles", n, 255);
        end
        chk("to_pulse", timeout_err, 1'b1);
        chk("to_src_ack", src_ack, 8'h02);
        chk("to_cnt", event_cnt, exp_cnt);
        tick(1);
        chk("to_pulse_end", timeout_err, 1'b0);
        src_req = '0;
        wait_src_ack(8'h00, "to_rel");

        // Asynchronous reset in the middle of a handshake.
        src_req = 8'h04;
        wait_req(1'b1, "ar_req");
        src_req = 8'h05;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req0", aer_req, 1'b0);
        chk("ar_addr0", aer_addr, 3'd0);
        chk("ar_busy0", busy, 1'b0);
        chk("ar_cnt0", event_cnt, 16'd0);
        chk("ar_ack0", src_ack, 8'h00);
        exp_cnt = '0;
        tick(2);
        rst_n = 1'b1;
        wait_req(1'b1, "ar_req_after");
        chk("ar_first_grant", aer_addr, 3'd0);
        aer_ack = 1'b1;
        wait_src_ack(8'h01, "ar_ack");
        exp_cnt = exp_cnt + 16'd1;
        chk("ar_cnt1", event_cnt, exp_cnt);
        src_req = '0;
        aer_ack = 1'b0;
        wait_src_ack(8'h00, "ar_rel");

        // Counter wrap from 0xFFFF.
        tick(2);
        force dut.event_cnt = 16'hFFFF;
        tick(2);
        release dut.event_cnt;
        tick(1);
        exp_cnt = 16'hFFFF;
        chk("wrap_pre", event_cnt, exp_cnt);
        serve(6, "wrap");
        chk("wrap_zero", event_cnt, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
